obstacle_spawner: RTL and testbench

Paces obstacle generation for the LCD dino game. It sits directly downstream of the pseudo-random generator. For each obstacle it requests one fresh random value, turns that value into an obstacle type and a frame gap, and counts the gap down on game frame ticks. It then offers the obstacle to the scroller/renderer over a valid/ready handshake. A difficulty counter shortens the minimum gap as more obstacles are delivered.

---
 rtl/obstacle_spawner.sv | 153 +++++++++++++++
 tb/tb_obstacle_spawner.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/obstacle_spawner.sv
// Obstacle pacing for the dino game: draws one random value per obstacle, counts the
// resulting gap down on frame ticks, then offers the obstacle. Macro OBSTACLE_BIRD_EN enables birds.
module obstacle_spawner #(
    parameter int unsigned MIN_GAP     = 40,
    parameter int unsigned FLOOR_GAP   = 16,
    parameter logic [5:0]  GAP_MASK    = 6'h3F,
    parameter int unsigned STEP_SPAWNS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr_i,
    input  logic        run_i,
    input  logic        tick_i,
    input  logic [7:0]  rnd_i,
    output logic        rnd_en_o,
    output logic        spawn_valid_o,
    input  logic        spawn_ready_i,
    output logic [1:0]  spawn_type_o,
    output logic [7:0]  cur_min_gap_o,
    output logic [15:0] spawn_count_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARM   = 3'd1;
    localparam logic [2:0] S_LATCH = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_OFFER = 3'd4;

`ifdef OBSTACLE_BIRD_EN
    localparam int TW = 2;
`else
    localparam int TW = 1;
`endif

    logic [2:0]    state_q, state_d;
    logic [8:0]    cnt_q, cnt_d;
    logic [TW-1:0] type_q, type_d;
    logic [7:0]    gap_q, gap_d;
    logic [7:0]    step_q, step_d;
    logic [15:0]   count_q, count_d;
    logic          rnd_en_q;
    logic          valid_q;
    logic          xfer_s;

    function automatic logic [TW-1:0] decode_type(input logic [1:0] r);
`ifdef OBSTACLE_BIRD_EN
        case (r)
            2'b10:   decode_type = 2'd1;
            2'b11:   decode_type = 2'd2;
            default: decode_type = 2'd0;
        endcase
`else
        case (r)
            2'b10, 2'b11: decode_type = 1'b1;
            default:      decode_type = 1'b0;
        endcase
`endif
    endfunction

    assign xfer_s = valid_q & spawn_ready_i;

    // Next-state logic; clr beats run, and run=0 beats a simultaneous transfer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        type_d  = type_q;
        gap_d   = gap_q;
        step_d  = step_q;
        count_d = count_q;
        if (clr_i) begin
            state_d = S_IDLE;
            gap_d   = 8'(MIN_GAP);
            step_d  = 8'd0;
            count_d = 16'd0;
        end else if (!run_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  state_d = S_ARM;
                S_ARM:   state_d = S_LATCH;
                S_LATCH: begin
                    type_d  = decode_type(rnd_i[7:6]);
                    cnt_d   = {1'b0, gap_q} + {3'b000, rnd_i[5:0] & GAP_MASK};
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (tick_i) begin
                        if (cnt_q <= 9'd1) begin
                            state_d = S_OFFER;
                        end else begin
                            cnt_d = cnt_q - 9'd1;
                        end
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                S_OFFER: begin
                    if (xfer_s) begin
                        count_d = count_q + 16'd1;
                        state_d = S_ARM;
                        if (step_q + 8'd1 == 8'(STEP_SPAWNS)) begin
                            step_d = 8'd0;
                            if (gap_q > 8'(FLOOR_GAP)) begin
                                gap_d = gap_q - 8'd1;
                            end else begin
                                gap_d = 8'(FLOOR_GAP);
                            end
                        end else begin
                            step_d = step_q + 8'd1;
                        end
                    end else begin
                        state_d = S_OFFER;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and registered strobes, decoded from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 9'd0;
            type_q   <= '0;
            gap_q    <= 8'(MIN_GAP);
            step_q   <= 8'd0;
            count_q  <= 16'd0;
            rnd_en_q <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            type_q   <= type_d;
            gap_q    <= gap_d;
            step_q   <= step_d;
            count_q  <= count_d;
            rnd_en_q <= (state_d == S_ARM);
            valid_q  <= (state_d == S_OFFER);
        end
    end

    assign rnd_en_o      = rnd_en_q;
    assign spawn_valid_o = valid_q;
    assign cur_min_gap_o = gap_q;
    assign spawn_count_o = count_q;
`ifdef OBSTACLE_BIRD_EN
    assign spawn_type_o  = type_q;
`else
    assign spawn_type_o  = {1'b0, type_q};
`endif

endmodule

// File: tb/tb_obstacle_spawner.sv
// Self-checking bench for obstacle_spawner: table vectors, randomized obstacles against a
// transaction-level model, and hand sequences for run/clr corner cases.
module tb_obstacle_spawner;

    localparam int MIN_GAP     = 40;
    localparam int FLOOR_GAP   = 16;
    localparam int STEP_SPAWNS = 8;
`ifdef OBSTACLE_BIRD_EN
    localparam int TYPE_TOP = 2;
`else
    localparam int TYPE_TOP = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n, clr, run, tick, ready;
    logic [7:0]  rnd;
    logic        rnd_en, valid;
    logic [1:0]  stype;
    logic [7:0]  min_gap;
    logic [15:0] count;

    int n_cmp = 0;
    int n_bad = 0;
    int m_count = 0;

    typedef struct {
        logic [7:0] r;
        int         exp_type;
        int         exp_gap;
        int         tick_period;
        int         hold;
    } vec_t;

    vec_t tbl[6];

    obstacle_spawner dut (
        .clk(clk), .rst_n(rst_n), .clr_i(clr), .run_i(run), .tick_i(tick),
        .rnd_i(rnd), .rnd_en_o(rnd_en), .spawn_valid_o(valid),
        .spawn_ready_i(ready), .spawn_type_o(stype),
        .cur_min_gap_o(min_gap), .spawn_count_o(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_min();
        int v;
        v = MIN_GAP - m_count / STEP_SPAWNS;
        return (v < FLOOR_GAP) ? FLOOR_GAP : v;
    endfunction

    function automatic int model_type(input logic [7:0] r);
        if (r < 8'h80) return 0;
        if (r < 8'hC0) return 1;
        return TYPE_TOP;
    endfunction

    // Starts in an ARM cycle; ends in the ARM cycle after the transfer.
    task automatic run_obstacle(input logic [7:0] r, input int etype, input int egap,
                                input int period, input int hold);
        int n, cyc;
        bit early, unstable;
        logic [1:0] held;
        chk("arm_rnd_en", rnd_en, 1'b1);
        rnd  = r;
        tick = 1'b1;
        step();
        chk("latch_rnd_en_low", rnd_en, 1'b0);
        step();
        rnd = 8'($urandom);
        n = 0; cyc = 0; early = 1'b0;
        while (n < egap && cyc < 4000) begin
            if (period > 0) tick = ((cyc % period) == period - 1);
            else            tick = ($urandom_range(0, 3) != 0);
            if (tick) n++;
            cyc++;
            step();
            if (n < egap && valid) early = 1'b1;
        end
        tick = 1'b0;
        chk("gap_in_budget", (n == egap), 1'b1);
        chk("early_valid", early, 1'b0);
        chk("valid_after_gap", valid, 1'b1);
        chk("spawn_type", stype, etype);
        held = stype; unstable = 1'b0;
        for (int h = 0; h < hold; h++) begin
            tick = 1'($urandom_range(0, 1));
            step();
            if (!valid || stype !== held) unstable = 1'b1;
        end
        tick = 1'b0;
        chk("offer_stable", unstable, 1'b0);
        ready = 1'b1;
        step();
        ready = 1'b0;
        m_count++;
        chk("valid_drop_after_xfer", valid, 1'b0);
        chk("spawn_count", count, 16'(m_count));
        chk("cur_min_gap", min_gap, exp_min());
        chk("rnd_en_after_xfer", rnd_en, 1'b1);
    endtask

    // From ARM, walk to OFFER using a tick every cycle.
    task automatic reach_offer(input logic [7:0] r);
        int cyc;
        rnd = r;
        step();
        step();
        tick = 1'b1;
        cyc = 0;
        while (!valid && cyc < 400) begin
            step();
            cyc++;
        end
        tick = 1'b0;
        chk("reach_offer", valid, 1'b1);
    endtask

    initial begin
        tbl[0] = '{8'h45, 0,        45,  4, 0};
        tbl[1] = '{8'hC3, TYPE_TOP, 43,  4, 10};
        tbl[2] = '{8'h80, 1,        40,  1, 2};
        tbl[3] = '{8'h3F, 0,        103, 2, 0};
        tbl[4] = '{8'hFF, TYPE_TOP, 103, 1, 3};
        tbl[5] = '{8'h7A, 0,        98,  3, 1};

        rst_n = 1'b0; clr = 1'b0; run = 1'b0; tick = 1'b0; ready = 1'b0; rnd = 8'h00;
        step(); step();
        rst_n = 1'b1;
        step();
        chk("rst_rnd_en", rnd_en, 1'b0);
        chk("rst_valid", valid, 1'b0);
        chk("rst_type", stype, 2'd0);
        chk("rst_min_gap", min_gap, 8'd40);
        chk("rst_count", count, 16'd0);

        run = 1'b1;
        step();
        for (int i = 0; i < 6; i++) begin
            run_obstacle(tbl[i].r, tbl[i].exp_type, tbl[i].exp_gap,
                         tbl[i].tick_period, tbl[i].hold);
        end

        while (m_count < 200) begin
            logic [7:0] r;
            r = 8'($urandom);
            run_obstacle(r, model_type(r), exp_min() + int'(r[5:0]), 0, $urandom_range(0, 2));
            if (m_count == 8)   chk("gap_at_8", min_gap, 8'd39);
            if (m_count == 192) chk("gap_at_192", min_gap, 8'd16);
            if (m_count == 200) chk("gap_at_200", min_gap, 8'd16);
        end
        chk("count_200", count, 16'd200);

        // run dropped mid-WAIT
        rnd = 8'h10;
        step(); step();
        tick = 1'b1; step(); step(); step();
        tick = 1'b0;
        run = 1'b0;
        step();
        chk("drop_wait_valid", valid, 1'b0);
        chk("drop_wait_rnd_en", rnd_en, 1'b0);
        chk("drop_wait_count", count, 16'd200);
        step();
        chk("idle_rnd_en", rnd_en, 1'b0);
        run = 1'b1;
        step();
        chk("restart_arm", rnd_en, 1'b1);

        // run=0 together with ready in OFFER
        reach_offer(8'h00);
        run = 1'b0; ready = 1'b1;
        step();
        ready = 1'b0;
        chk("drop_offer_valid", valid, 1'b0);
        chk("drop_offer_count", count, 16'd200);
        chk("drop_offer_rnd_en", rnd_en, 1'b0);
        run = 1'b1;
        step();
        chk("restart_arm2", rnd_en, 1'b1);

        // clr in OFFER with ready
        reach_offer(8'h01);
        clr = 1'b1; ready = 1'b1;
        step();
        clr = 1'b0; ready = 1'b0;
        chk("clr_valid", valid, 1'b0);
        chk("clr_count", count, 16'd0);
        chk("clr_min_gap", min_gap, 8'd40);
        chk("clr_rnd_en", rnd_en, 1'b0);
        step();
        chk("clr_then_arm", rnd_en, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
